tm_shiftreg_sequencer: RTL

Drives the TM serial shift register from the wide configuration word produced by the config-word combiner. On a start pulse it latches the word and shifts it out MSB-first with a programmable-rate serial clock. It captures the bits shifted out of the chain, issues a load strobe, and reports completion plus a readback mismatch flag. It sits between the combiner output and the TM shift-register pins on the KC705 test firmware.

---
 rtl/tm_shiftreg_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tm_shiftreg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tm_shiftreg_sequencer
// Purpose  : Serialises a wide configuration word into the TM shift-register
//            chain MSB-first with a programmable-rate serial clock, captures
//            the bits returned from the end of the chain, pulses the parallel
//            load strobe and flags a readback mismatch against the word
//            written by the previous sequence.
// Ports    : clk_in   - control clock
//            rst      - asynchronous reset, active-high
//            data_in  - configuration word from the combiner
//            start    - single-cycle request to begin a write sequence
//            div      - sr_clk half-period in clk_in cycles (0 behaves as 1)
//            sr_clk   - serial shift clock to the TM register
//            sr_din   - serial data to the TM register
//            sr_load  - parallel-load strobe to the TM register
//            sr_dout  - serial data returned from the end of the chain
//            busy     - high while a sequence is in progress
//            done     - one-cycle pulse at sequence end
//            data_rb  - word captured from sr_dout during the last sequence
//            mismatch - data_rb differed from the previously written word
// Revision : 1.0 - initial release
// ============================================================================
module tm_shiftreg_sequencer #(
    parameter int DATA_WIDTH = 170,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic                  sr_clk,
    output logic                  sr_din,
    output logic                  sr_load,
    input  logic                  sr_dout,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_rb,
    output logic                  mismatch
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LOAD     = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] readback_q, readback_d;
    logic [DATA_WIDTH-1:0] prev_word_q, prev_word_d;
    logic [DATA_WIDTH-1:0] data_rb_q, data_rb_d;
    logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  sr_clk_q, sr_clk_d;
    logic                  sr_din_q, sr_din_d;
    logic                  sr_load_q, sr_load_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mismatch_q, mismatch_d;
    logic                  phase_end;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            readback_q  <= '0;
            prev_word_q <= '0;
            data_rb_q   <= '0;
            div_lat_q   <= DIV_ONE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sr_clk_q    <= 1'b0;
            sr_din_q    <= 1'b0;
            sr_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            readback_q  <= readback_d;
            prev_word_q <= prev_word_d;
            data_rb_q   <= data_rb_d;
            div_lat_q   <= div_lat_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_clk_q    <= sr_clk_d;
            sr_din_q    <= sr_din_d;
            sr_load_q   <= sr_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
        end
    end

    // Last cycle of the current d-cycle phase (SHIFT_LO, SHIFT_HI or LOAD).
    assign phase_end = (div_cnt_q == (div_lat_q - DIV_ONE));

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        readback_d  = readback_q;
        prev_word_d = prev_word_q;
        data_rb_d   = data_rb_q;
        div_lat_d   = div_lat_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        mismatch_d  = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d   = data_in;
                    div_lat_d  = (div == '0) ? DIV_ONE : div;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    readback_d = '0;
                    state_d    = ST_SHIFT_LO;
                end
            end

            ST_SHIFT_LO: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT_HI;
                    // The chain advances on the rising sr_clk that follows this
                    // edge, so sr_dout still holds the bit about to leave it.
                    readback_d = {readback_q[DATA_WIDTH-2:0], sr_dout};
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end

            ST_SHIFT_HI: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    // Rotate rather than shift: only the MSB is ever driven,
                    // and after DATA_WIDTH rotations the shadow again holds the
                    // word latched at start, which becomes prev_word.
                    shadow_d  = {shadow_q[DATA_WIDTH-2:0], shadow_q[DATA_WIDTH-1]};
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_LOAD : ST_SHIFT_LO;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end

            ST_LOAD: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    state_d   = ST_FINISH;
                    // Results update on the edge entering FINISH so they are
                    // already valid while done is high.
                    data_rb_d   = readback_q;
                    mismatch_d  = (readback_q != prev_word_q);
                    prev_word_d = shadow_q;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state they belong to.
        sr_clk_d  = (state_d == ST_SHIFT_HI);
        sr_din_d  = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI))
                    ? shadow_d[DATA_WIDTH-1] : 1'b0;
        sr_load_d = (state_d == ST_LOAD);
        busy_d    = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) ||
                    (state_d == ST_LOAD);
        done_d    = (state_d == ST_FINISH);
    end

    assign sr_clk   = sr_clk_q;
    assign sr_din   = sr_din_q;
    assign sr_load  = sr_load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_rb  = data_rb_q;
    assign mismatch = mismatch_q;

endmodule
`default_nettype wire
